// File: rtl/interrupt_controller.sv
// INTCON register, Timer0/INT flag capture and interrupt entry/return sequencing.
// Optional build macro INT_PIN_SYNC_EN adds a 2-flop synchroniser on int_pin.
module interrupt_controller #(
  parameter int              PC_W        = 13,
  parameter logic [PC_W-1:0] VECTOR_ADDR = 13'h004
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      q_count,
  input  logic            boundary_ok,
  input  logic            retfie_exec,
  input  logic            tmr0_ovf,
  input  logic            int_pin,
  input  logic            intcon_wr_en,
  input  logic [7:0]      intcon_wr_data,
  output logic [7:0]      intcon_rd_data,
  output logic            int_vector_en,
  output logic            int_flush,
  output logic [PC_W-1:0] int_vector_addr,
  output logic            int_active,
  output logic            wake
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VECTOR  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   gie_q, gie_d;
  logic   intedg_q, intedg_d;
  logic   t0ie_q, t0ie_d;
  logic   inte_q, inte_d;
  logic   t0if_q, t0if_d;
  logic   intf_q, intf_d;
  logic   pin_prev_q;
  logic   pin_s;
  logic   edge_s;
  logic   pending_s;

`ifdef INT_PIN_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= int_pin;
      sync2_q <= sync1_q;
    end
  end

  assign pin_s = sync2_q;
`else
  assign pin_s = int_pin;
`endif

  // Edge is judged on the pin history only, so toggling INTEDG alone never fires.
  assign edge_s    = intedg_q ? (pin_s & ~pin_prev_q) : (~pin_s & pin_prev_q);
  assign pending_s = (t0if_q & t0ie_q) | (intf_q & inte_q);

  always_comb begin
    state_d  = state_q;
    gie_d    = gie_q;
    intedg_d = intedg_q;
    t0ie_d   = t0ie_q;
    inte_d   = inte_q;
    t0if_d   = t0if_q;
    intf_d   = intf_q;

    if (intcon_wr_en) begin
      gie_d    = intcon_wr_data[7];
      intedg_d = intcon_wr_data[6];
      t0ie_d   = intcon_wr_data[5];
      inte_d   = intcon_wr_data[4];
      t0if_d   = intcon_wr_data[2];
      intf_d   = intcon_wr_data[1];
    end else begin
      gie_d    = gie_q;
    end

    if (tmr0_ovf) begin
      t0if_d = 1'b1;
    end else begin
      t0if_d = t0if_d;
    end

    if (edge_s) begin
      intf_d = 1'b1;
    end else begin
      intf_d = intf_d;
    end

    // Entry decision looks only at registered values, so a same-cycle write cannot cancel it.
    case (state_q)
      ST_IDLE: begin
        if ((q_count == 2'd2) && gie_q && pending_s && boundary_ok) begin
          state_d = ST_VECTOR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VECTOR: begin
        gie_d   = 1'b0;
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if ((q_count == 2'd3) && retfie_exec) begin
          gie_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (intcon_wr_en && intcon_wr_data[7]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gie_q      <= 1'b0;
      intedg_q   <= 1'b0;
      t0ie_q     <= 1'b0;
      inte_q     <= 1'b0;
      t0if_q     <= 1'b0;
      intf_q     <= 1'b0;
      pin_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gie_q      <= gie_d;
      intedg_q   <= intedg_d;
      t0ie_q     <= t0ie_d;
      inte_q     <= inte_d;
      t0if_q     <= t0if_d;
      intf_q     <= intf_d;
      pin_prev_q <= pin_s;
    end
  end

  assign intcon_rd_data  = {gie_q, intedg_q, t0ie_q, inte_q, 1'b0, t0if_q, intf_q, 1'b0};
  assign int_vector_en   = (state_q == ST_VECTOR);
  assign int_flush       = (state_q == ST_VECTOR);
  assign int_active      = (state_q == ST_SERVICE);
  assign int_vector_addr = VECTOR_ADDR;
  assign wake            = pending_s;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; works with or without INT_PIN_SYNC_EN.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  q_count;
  logic        boundary_ok;
  logic        retfie_exec;
  logic        tmr0_ovf;
  logic        int_pin;
  logic        intcon_wr_en;
  logic [7:0]  intcon_wr_data;
  logic [7:0]  intcon_rd_data;
  logic        int_vector_en;
  logic        int_flush;
  logic [12:0] int_vector_addr;
  logic        int_active;
  logic        wake;

  int n_total = 0;
  int n_bad   = 0;

  interrupt_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .q_count         (q_count),
    .boundary_ok     (boundary_ok),
    .retfie_exec     (retfie_exec),
    .tmr0_ovf        (tmr0_ovf),
    .int_pin         (int_pin),
    .intcon_wr_en    (intcon_wr_en),
    .intcon_wr_data  (intcon_wr_data),
    .intcon_rd_data  (intcon_rd_data),
    .int_vector_en   (int_vector_en),
    .int_flush       (int_flush),
    .int_vector_addr (int_vector_addr),
    .int_active      (int_active),
    .wake            (wake)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample point and input update both sit 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    q_count = q_count + 2'd1;
  endtask

  task automatic run_to(input logic [1:0] target);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (q_count != target && n < 8);
    if (q_count != target) check("run_to_timeout", 16'(q_count), 16'(target));
  endtask

  task automatic wr(input logic [7:0] d);
    intcon_wr_en   = 1'b1;
    intcon_wr_data = d;
    cyc();
    intcon_wr_en   = 1'b0;
  endtask

  initial begin
    int intf_lat;
    int vec_at;
    logic [1:0] vec_q;
    logic any_vec;

    rst_n = 1'b0; q_count = 2'd0; boundary_ok = 1'b1; retfie_exec = 1'b0;
    tmr0_ovf = 1'b0; int_pin = 1'b0; intcon_wr_en = 1'b1; intcon_wr_data = 8'hFF;
    cyc(); cyc();
    check("rst_rd",     16'(intcon_rd_data), 16'h0000);
    check("rst_vec",    16'(int_vector_en),  16'h0000);
    check("rst_flush",  16'(int_flush),      16'h0000);
    check("rst_active", 16'(int_active),     16'h0000);
    check("rst_wake",   16'(wake),           16'h0000);
    intcon_wr_en = 1'b0;
    rst_n = 1'b1;

    // Timer0 entry
    run_to(2'd0);
    wr(8'hA0);
    check("t0_wr", 16'(intcon_rd_data), 16'h00A0);
    tmr0_ovf = 1'b1; cyc(); tmr0_ovf = 1'b0;
    check("t0_flag", 16'(intcon_rd_data), 16'h00A4);
    check("t0_wake", 16'(wake), 16'h0001);
    check("t0_q2_novec", 16'(int_vector_en), 16'h0000);
    cyc();
    check("t0_q", 16'(q_count), 16'h0003);
    check("t0_vec", 16'(int_vector_en), 16'h0001);
    check("t0_flush", 16'(int_flush), 16'h0001);
    check("t0_addr", 16'(int_vector_addr), 16'h0004);
    cyc();
    check("t0_vec_off", 16'(int_vector_en), 16'h0000);
    check("t0_flush_off", 16'(int_flush), 16'h0000);
    check("t0_active", 16'(int_active), 16'h0001);
    check("t0_gie_clr", 16'(intcon_rd_data), 16'h0024);

    // RETFIE with T0IF still set: re-entry at the next instruction
    run_to(2'd3);
    check("ret_q3_novec", 16'(int_vector_en), 16'h0000);
    retfie_exec = 1'b1; cyc(); retfie_exec = 1'b0;
    check("ret_rd", 16'(intcon_rd_data), 16'h00A4);
    check("ret_idle", 16'(int_active), 16'h0000);
    cyc(); cyc();
    check("ret_q2_novec", 16'(int_vector_en), 16'h0000);
    cyc();
    check("reent_vec", 16'(int_vector_en), 16'h0001);
    cyc();
    check("reent_active", 16'(int_active), 16'h0001);
    check("reent_rd", 16'(intcon_rd_data), 16'h0024);
    wr(8'h00);
    check("svc_gie0_stay", 16'(int_active), 16'h0001);
    wr(8'h80);
    check("svc_gie1_exit", 16'(int_active), 16'h0000);
    check("svc_exit_rd", 16'(intcon_rd_data), 16'h0080);

    // Deferral over two non-boundary instructions
    run_to(2'd0);
    boundary_ok = 1'b0;
    wr(8'hA0);
    tmr0_ovf = 1'b1; cyc(); tmr0_ovf = 1'b0;
    run_to(2'd3);
    check("def_i1", 16'(int_vector_en), 16'h0000);
    run_to(2'd3);
    check("def_i2", 16'(int_vector_en), 16'h0000);
    run_to(2'd0);
    boundary_ok = 1'b1;
    run_to(2'd3);
    check("def_i3_vec", 16'(int_vector_en), 16'h0001);
    cyc();
    check("def_active", 16'(int_active), 16'h0001);
    check("def_rd", 16'(intcon_rd_data), 16'h0024);
    wr(8'h80);
    check("def_exit", 16'(int_active), 16'h0000);

    // INT rising edge, latency 1 (direct) or 3 (synchronised)
    wr(8'hD0);
    check("int_wr", 16'(intcon_rd_data), 16'h00D0);
    int_pin = 1'b1;
    intf_lat = 0; vec_at = 0; vec_q = 2'd0;
    for (int i = 1; i <= 16 && vec_at == 0; i++) begin
      cyc();
      if (intf_lat == 0 && intcon_rd_data[1]) intf_lat = i;
      if (int_vector_en) begin
        vec_at = i;
        vec_q  = q_count;
      end
    end
    check("int_lat_ok", 16'((intf_lat == 1) || (intf_lat == 3)), 16'h0001);
    check("int_vec_seen", 16'(vec_at != 0), 16'h0001);
    check("int_vec_q3", 16'(vec_q), 16'h0003);
    cyc();
    check("int_active", 16'(int_active), 16'h0001);
    check("int_rd", 16'(intcon_rd_data), 16'h0052);
    wr(8'h90);
    check("int_exit", 16'(int_active), 16'h0000);
    wr(8'h10);
    check("int_edg0_wr", 16'(intcon_rd_data), 16'h0010);
    int_pin = 1'b0;
    repeat (6) cyc();
    check("int_fall_set", 16'(intcon_rd_data), 16'h0012);
    check("int_fall_wake", 16'(wake), 16'h0001);
    wr(8'h10);
    check("int_clr_wake", 16'(wake), 16'h0000);
    int_pin = 1'b1;
    repeat (6) cyc();
    check("int_rise_noset", 16'(intcon_rd_data), 16'h0010);
    wr(8'h50);
    repeat (6) cyc();
    check("int_edg_chg_noset", 16'(intcon_rd_data), 16'h0050);

    // Collision: hardware set wins over a clearing write; no entry with GIE=0
    intcon_wr_en = 1'b1; intcon_wr_data = 8'h20; tmr0_ovf = 1'b1;
    cyc();
    intcon_wr_en = 1'b0; tmr0_ovf = 1'b0;
    check("col_rd", 16'(intcon_rd_data), 16'h0024);
    check("col_wake", 16'(wake), 16'h0001);
    any_vec = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      any_vec = any_vec | int_vector_en;
    end
    check("col_novec", 16'(any_vec), 16'h0000);

    // Write in the decision cycle does not cancel entry
    run_to(2'd0);
    wr(8'hA4);
    cyc();
    check("pw_q2", 16'(q_count), 16'h0002);
    wr(8'h00);
    check("pw_vec", 16'(int_vector_en), 16'h0001);
    check("pw_rd", 16'(intcon_rd_data), 16'h0000);
    cyc();
    check("pw_active", 16'(int_active), 16'h0001);

    // Reset asserted mid-VECTOR
    wr(8'hA4);
    check("rv_idle", 16'(int_active), 16'h0000);
    cyc(); cyc();
    check("rv_vec", 16'(int_vector_en), 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rv_vec_drop", 16'(int_vector_en), 16'h0000);
    check("rv_flush_drop", 16'(int_flush), 16'h0000);
    check("rv_rd", 16'(intcon_rd_data), 16'h0000);
    check("rv_wake", 16'(wake), 16'h0000);
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    check("rv_after_active", 16'(int_active), 16'h0000);
    check("rv_after_vec", 16'(int_vector_en), 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Owns the INTCON register and the interrupt sources: Timer0 overflow and the external INT pin.
- At a safe instruction boundary it sequences interrupt entry by forcing a jump-and-push to the vector address plus an instruction flush, the same way a CALL does.
- Tracks service state until RETFIE; sits beside the instruction decoder and drives the PC/stack and instruction-register control muxes.

Parameters:
- PC_W, 13, program counter width
- VECTOR_ADDR, 13'h004, interrupt vector address

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- q_count  in  2  decoder Q-cycle count; 0..3, 3 = last cycle of instruction
- boundary_ok  in  1  current instruction ends in plain pc_incr (no flush, jump, skip-taken, pop); valid during q_count==2
- retfie_exec  in  1  RETFIE executing; sampled when q_count==3
- tmr0_ovf  in  1  one-clock Timer0 overflow pulse
- int_pin  in  1  external interrupt pin, asynchronous
- intcon_wr_en  in  1  register-file write strobe for INTCON
- intcon_wr_data  in  8  write data
- intcon_rd_data  out  8  INTCON read value
- int_vector_en  out  1  force PC := int_vector_addr and push PC+1
- int_flush  out  1  flush fetched instruction
- int_vector_addr  out  PC_W  equals VECTOR_ADDR
- int_active  out  1  handler in service
- wake  out  1  an enabled flag is set, regardless of GIE; used by sleep logic

Behaviour:
- INTCON bit map:
  - 7 GIE, 6 INTEDG (1 = rising edge), 5 T0IE, 4 INTE, 2 T0IF, 1 INTF.
  - Bits 3 and 0 read 0 and ignore writes.
  - All bits reset to 0.
- Flags:
  - T0IF is set by tmr0_ovf.
  - INTF is set by the selected edge on the synchronised pin.
  - A hardware set and a software write in the same cycle: hardware set wins for that flag bit; the other bits take the write data.
- Edge detection:
  - Previous-sample register resets to 0, so a pin held high at reset release gives a rising edge once sampled.
  - Changing INTEDG does not itself generate an edge.
- pending = (T0IF & T0IE) | (INTF & INTE). wake = pending.
- State machine (reset IDLE):
  - IDLE: at the clock edge ending q_count==2, if GIE & pending & boundary_ok -> VECTOR. Otherwise stay.
  - VECTOR: lasts exactly the q_count==3 cycle. int_vector_en=1 and int_flush=1 are combinational outputs of this state. At the edge ending that cycle: GIE:=0, -> SERVICE.
  - SERVICE: int_active=1. If retfie_exec at q_count==3 -> GIE:=1, -> IDLE. A software write with GIE=1 -> IDLE (nesting allowed). Software write with GIE=0 -> stay.
- Output reset values: int_vector_en, int_flush, int_active and wake are 0; intcon_rd_data is 0x00.
- Entry latency: the flag is visible in INTCON the cycle after its source event. Entry occurs at the first boundary whose q_count==2 edge samples the flag set with GIE=1.
- Flags are not auto-cleared on entry; the handler clears them by software.
- Software write to INTCON in the same cycle as the IDLE->VECTOR decision: the decision uses pre-write register values; VECTOR still completes.
- RETFIE with a flag still pending: GIE=1 at the end of q3. Re-entry happens at the next eligible boundary, never the same instruction.
- boundary_ok=0 (goto, call, return, retlw, taken skip, NOP flush): entry is deferred to a later boundary.
- rst_n asserted mid-VECTOR: outputs drop immediately, state returns to IDLE.
- int_vector_en and retfie_exec are never both asserted; the decoder guarantees this.

Optional Feature:
- Macro: INT_PIN_SYNC_EN.
- Defined: int_pin passes through a 2-flop synchroniser (reset 0) before the edge-detect register. Pin-to-INTF latency is 3 clocks.
- Undefined: int_pin feeds the edge-detect register directly. Latency is 1 clock; for synchronous test benches and pin sources only.

Test Plan:
- Reset: hold rst_n=0, write 0xFF -> intcon_rd_data=0x00; all outputs 0; state IDLE.
- Timer0 entry: write INTCON=0xA0; pulse tmr0_ovf with boundary_ok=1.
  - Expect T0IF=1 (reads 0xA4).
  - int_vector_en=1 and int_flush=1 for exactly the next q_count==3 cycle; int_vector_addr=0x004.
  - Then GIE=0 (reads 0x24), int_active=1.
- Deferral: as above but boundary_ok=0 for two instructions, then 1 -> vector asserted only in the third instruction's q3.
- INT edge: INTCON=0xD0, drive int_pin 0->1 (INT_PIN_SYNC_EN defined).
  - Expect INTF set 3 clocks later, then entry.
  - With INTEDG=0 a 0->1 transition does not set INTF; a 1->0 transition does.
- RETFIE re-entry: in SERVICE with T0IF still 1, pulse retfie_exec at q3.
  - Expect GIE=1, IDLE.
  - Re-entry at the following instruction's q3, not the RETFIE's.
- Collision: write INTCON=0x20 in the same cycle as tmr0_ovf -> reads 0x24 (hardware set wins); wake=1 while GIE=0, int_vector_en stays 0.
